// File: rtl/imem_dmem_arbiter_if.sv
// Bus bundle between the pipeline (IF/DM requesters), the arbiter and the
// shared single-ported memory. The arbiter uses the slave modport; the
// pipeline/memory side uses the master modport.
interface imem_dmem_arbiter_if #(
  parameter int AW = 32,
  parameter int DW = 32
);
  // Instruction-fetch requester
  logic            if_req;
  logic [AW-1:0]   if_addr;
  logic            if_abort;
  logic [DW-1:0]   if_rdata;
  logic            if_ready;
  // Data-memory requester
  logic            dm_req;
  logic            dm_we;
  logic [DW/8-1:0] dm_be;
  logic [AW-1:0]   dm_addr;
  logic [DW-1:0]   dm_wdata;
  logic [DW-1:0]   dm_rdata;
  logic            dm_ready;
  // Shared memory bus
  logic            mem_req;
  logic            mem_we;
  logic [DW/8-1:0] mem_be;
  logic [AW-1:0]   mem_addr;
  logic [DW-1:0]   mem_wdata;
  logic            mem_ack;
  logic [DW-1:0]   mem_rdata;
  // Pipeline control
  logic            stall_if;
  logic            stall_dm;
  logic            busy;

  modport slave (
    input  if_req, if_addr, if_abort,
    output if_rdata, if_ready,
    input  dm_req, dm_we, dm_be, dm_addr, dm_wdata,
    output dm_rdata, dm_ready,
    output mem_req, mem_we, mem_be, mem_addr, mem_wdata,
    input  mem_ack, mem_rdata,
    output stall_if, stall_dm, busy
  );

  modport master (
    output if_req, if_addr, if_abort,
    input  if_rdata, if_ready,
    output dm_req, dm_we, dm_be, dm_addr, dm_wdata,
    input  dm_rdata, dm_ready,
    input  mem_req, mem_we, mem_be, mem_addr, mem_wdata,
    output mem_ack, mem_rdata,
    input  stall_if, stall_dm, busy
  );
endinterface

// File: rtl/imem_dmem_arbiter.sv
// Arbitrates one single-ported memory bus between instruction fetch (IF) and
// data memory (DM). DM has priority, but the requester that just completed
// is excluded from the grant at its ack edge, so under contention the two
// alternate and the bus stays busy with no idle cycle between them.
module imem_dmem_arbiter #(
  parameter int AW = 32,
  parameter int DW = 32
) (
  input  logic                 clk,
  input  logic                 rst_n,
  imem_dmem_arbiter_if.slave   bus
);
  localparam int BW = DW / 8;

  typedef enum logic [1:0] {IDLE, IF_WAIT, DM_WAIT} state_t;

  state_t          state_q, state_d;
  logic            mem_req_q, mem_req_d;
  logic            mem_we_q, mem_we_d;
  logic [BW-1:0]   mem_be_q, mem_be_d;
  logic [AW-1:0]   mem_addr_q, mem_addr_d;
  logic [DW-1:0]   mem_wdata_q, mem_wdata_d;
  logic [DW-1:0]   if_rdata_q, if_rdata_d;
  logic            if_ready_q, if_ready_d;
  logic [DW-1:0]   dm_rdata_q, dm_rdata_d;
  logic            dm_ready_q, dm_ready_d;
  logic            abort_flag_q, abort_flag_d;

  logic            if_done, dm_done, grant_eval, if_elig, dm_elig;

  // Completion/eligibility terms; a requester finishing at this edge may not re-win it.
  always_comb begin
    if_done    = (state_q == IF_WAIT) && bus.mem_ack;
    dm_done    = (state_q == DM_WAIT) && bus.mem_ack;
    grant_eval = (state_q == IDLE) || bus.mem_ack;
    dm_elig    = bus.dm_req && !dm_done;
    if_elig    = bus.if_req && !if_done && !bus.if_abort;
  end

  // Next-state, completion capture and grant decision.
  always_comb begin
    state_d      = state_q;
    mem_req_d    = mem_req_q;
    mem_we_d     = mem_we_q;
    mem_be_d     = mem_be_q;
    mem_addr_d   = mem_addr_q;
    mem_wdata_d  = mem_wdata_q;
    if_rdata_d   = if_rdata_q;
    if_ready_d   = 1'b0;
    dm_rdata_d   = dm_rdata_q;
    dm_ready_d   = 1'b0;
    abort_flag_d = abort_flag_q;

    if (dm_done) begin
      dm_ready_d = 1'b1;
      if (!mem_we_q) dm_rdata_d = bus.mem_rdata;
    end

    // An abort arriving together with the ack also suppresses delivery.
    if (if_done) begin
      if_rdata_d   = bus.mem_rdata;
      if_ready_d   = !(abort_flag_q || bus.if_abort);
      abort_flag_d = 1'b0;
    end else if ((state_q == IF_WAIT) && bus.if_abort) begin
      abort_flag_d = 1'b1;
    end

    if (grant_eval) begin
      if (dm_elig) begin
        state_d     = DM_WAIT;
        mem_req_d   = 1'b1;
        mem_we_d    = bus.dm_we;
        mem_be_d    = bus.dm_be;
        mem_addr_d  = bus.dm_addr;
        mem_wdata_d = bus.dm_wdata;
      end else if (if_elig) begin
        state_d      = IF_WAIT;
        mem_req_d    = 1'b1;
        mem_we_d     = 1'b0;
        mem_be_d     = '1;
        mem_addr_d   = bus.if_addr;
        mem_wdata_d  = '0;
        abort_flag_d = 1'b0;
      end else begin
        state_d   = IDLE;
        mem_req_d = 1'b0;
      end
    end
  end

  // State and registered outputs; reset clears everything immediately.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      mem_req_q    <= 1'b0;
      mem_we_q     <= 1'b0;
      mem_be_q     <= '0;
      mem_addr_q   <= '0;
      mem_wdata_q  <= '0;
      if_rdata_q   <= '0;
      if_ready_q   <= 1'b0;
      dm_rdata_q   <= '0;
      dm_ready_q   <= 1'b0;
      abort_flag_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      mem_req_q    <= mem_req_d;
      mem_we_q     <= mem_we_d;
      mem_be_q     <= mem_be_d;
      mem_addr_q   <= mem_addr_d;
      mem_wdata_q  <= mem_wdata_d;
      if_rdata_q   <= if_rdata_d;
      if_ready_q   <= if_ready_d;
      dm_rdata_q   <= dm_rdata_d;
      dm_ready_q   <= dm_ready_d;
      abort_flag_q <= abort_flag_d;
    end
  end

  assign bus.mem_req   = mem_req_q;
  assign bus.mem_we    = mem_we_q;
  assign bus.mem_be    = mem_be_q;
  assign bus.mem_addr  = mem_addr_q;
  assign bus.mem_wdata = mem_wdata_q;
  assign bus.if_rdata  = if_rdata_q;
  assign bus.if_ready  = if_ready_q;
  assign bus.dm_rdata  = dm_rdata_q;
  assign bus.dm_ready  = dm_ready_q;
  assign bus.stall_if  = bus.if_req & ~if_ready_q;
  assign bus.stall_dm  = bus.dm_req & ~dm_ready_q;
  assign bus.busy      = (state_q != IDLE);
endmodule

// File: tb/tb_imem_dmem_arbiter.sv
// Directed bench for imem_dmem_arbiter: inputs change and outputs are checked
// on the falling clock edge, memory acks are driven by hand.
module tb_imem_dmem_arbiter;
  logic clk = 1'b0;
  logic rst_n;
  int   vectors = 0;
  int   miscompares = 0;

  imem_dmem_arbiter_if #(.AW(32), .DW(32)) bus ();

  imem_dmem_arbiter #(.AW(32), .DW(32)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  task automatic cyc();
    @(negedge clk);
  endtask

  task automatic test_reset();
    cyc();
    vectors++; if (bus.mem_req !== 1'b0) begin miscompares++; $display("FAIL rst_mem_req got %0h want 0", bus.mem_req); end
    vectors++; if (bus.busy !== 1'b0) begin miscompares++; $display("FAIL rst_busy got %0h want 0", bus.busy); end
    vectors++; if ({bus.if_ready, bus.dm_ready, bus.mem_we} !== 3'b000) begin miscompares++; $display("FAIL rst_ready_we got %b want 000", {bus.if_ready, bus.dm_ready, bus.mem_we}); end
    vectors++; if ({bus.mem_be, bus.mem_addr, bus.mem_wdata} !== 68'h0) begin miscompares++; $display("FAIL rst_bus got %h want 0", {bus.mem_be, bus.mem_addr, bus.mem_wdata}); end
    vectors++; if ({bus.if_rdata, bus.dm_rdata} !== 64'h0) begin miscompares++; $display("FAIL rst_rdata got %h want 0", {bus.if_rdata, bus.dm_rdata}); end
    rst_n = 1'b1;
  endtask

  task automatic test_single_fetch();
    bus.if_req = 1'b1; bus.if_addr = 32'h0000_0040;
    #1;
    vectors++; if (bus.stall_if !== 1'b1) begin miscompares++; $display("FAIL fetch_stall_early got %0h want 1", bus.stall_if); end
    cyc();
    vectors++; if (bus.mem_req !== 1'b1) begin miscompares++; $display("FAIL fetch_mem_req got %0h want 1", bus.mem_req); end
    vectors++; if (bus.mem_addr !== 32'h40) begin miscompares++; $display("FAIL fetch_addr got %h want 40", bus.mem_addr); end
    vectors++; if ({bus.mem_we, bus.mem_be} !== 5'b0_1111) begin miscompares++; $display("FAIL fetch_we_be got %b want 01111", {bus.mem_we, bus.mem_be}); end
    vectors++; if (bus.mem_wdata !== 32'h0) begin miscompares++; $display("FAIL fetch_wdata got %h want 0", bus.mem_wdata); end
    cyc();
    vectors++; if ({bus.mem_req, bus.if_ready, bus.stall_if} !== 3'b101) begin miscompares++; $display("FAIL fetch_wait got %b want 101", {bus.mem_req, bus.if_ready, bus.stall_if}); end
    bus.mem_ack = 1'b1; bus.mem_rdata = 32'h2408_0005;
    cyc();
    vectors++; if (bus.if_ready !== 1'b1) begin miscompares++; $display("FAIL fetch_ready got %0h want 1", bus.if_ready); end
    vectors++; if (bus.if_rdata !== 32'h2408_0005) begin miscompares++; $display("FAIL fetch_rdata got %h want 24080005", bus.if_rdata); end
    vectors++; if ({bus.stall_if, bus.mem_req, bus.busy} !== 3'b000) begin miscompares++; $display("FAIL fetch_done_ctl got %b want 000", {bus.stall_if, bus.mem_req, bus.busy}); end
    bus.mem_ack = 1'b0; bus.if_req = 1'b0;
    cyc();
    vectors++; if (bus.if_ready !== 1'b0) begin miscompares++; $display("FAIL fetch_pulse_len got %0h want 0", bus.if_ready); end
  endtask

  task automatic test_contention();
    bus.if_req = 1'b1; bus.if_addr = 32'h200;
    bus.dm_req = 1'b1; bus.dm_we = 1'b1; bus.dm_be = 4'h3; bus.dm_addr = 32'h100; bus.dm_wdata = 32'hDEAD_BEEF;
    cyc();
    vectors++; if ({bus.mem_req, bus.mem_we, bus.mem_be} !== 6'b11_0011) begin miscompares++; $display("FAIL cont_store_ctl got %b want 110011", {bus.mem_req, bus.mem_we, bus.mem_be}); end
    vectors++; if ({bus.mem_addr, bus.mem_wdata} !== 64'h0000_0100_DEAD_BEEF) begin miscompares++; $display("FAIL cont_store_bus got %h want 00000100deadbeef", {bus.mem_addr, bus.mem_wdata}); end
    vectors++; if ({bus.stall_dm, bus.stall_if} !== 2'b11) begin miscompares++; $display("FAIL cont_stalls got %b want 11", {bus.stall_dm, bus.stall_if}); end
    bus.mem_ack = 1'b1; bus.mem_rdata = 32'h1111_1111;
    cyc();
    vectors++; if ({bus.dm_ready, bus.if_ready, bus.stall_dm} !== 3'b100) begin miscompares++; $display("FAIL cont_dm_ready got %b want 100", {bus.dm_ready, bus.if_ready, bus.stall_dm}); end
    vectors++; if (bus.mem_req !== 1'b1) begin miscompares++; $display("FAIL cont_b2b_req got %0h want 1", bus.mem_req); end
    vectors++; if ({bus.mem_we, bus.mem_be, bus.mem_addr} !== 37'h0F_0000_0200) begin miscompares++; $display("FAIL cont_fetch_bus got %h want 0f00000200", {bus.mem_we, bus.mem_be, bus.mem_addr}); end
    vectors++; if (bus.dm_rdata !== 32'h0) begin miscompares++; $display("FAIL cont_store_rdata got %h want 0", bus.dm_rdata); end
    bus.dm_req = 1'b0; bus.mem_rdata = 32'hCAFE_F00D;
    cyc();
    vectors++; if ({bus.if_ready, bus.dm_ready, bus.mem_req} !== 3'b100) begin miscompares++; $display("FAIL cont_if_ready got %b want 100", {bus.if_ready, bus.dm_ready, bus.mem_req}); end
    vectors++; if (bus.if_rdata !== 32'hCAFE_F00D) begin miscompares++; $display("FAIL cont_if_rdata got %h want cafef00d", bus.if_rdata); end
    bus.mem_ack = 1'b0; bus.if_req = 1'b0;
    cyc();
    vectors++; if (bus.busy !== 1'b0) begin miscompares++; $display("FAIL cont_idle got %0h want 0", bus.busy); end
  endtask

  task automatic test_alternation();
    bus.if_req = 1'b1; bus.if_addr = 32'h300;
    bus.dm_req = 1'b1; bus.dm_we = 1'b0; bus.dm_be = 4'hF; bus.dm_addr = 32'h400;
    bus.mem_ack = 1'b1; bus.mem_rdata = 32'h5555_AAAA;
    for (int i = 0; i < 6; i++) begin
      logic [31:0] exp_addr;
      cyc();
      exp_addr = (i % 2 == 0) ? 32'h400 : 32'h300;
      vectors++; if ({bus.mem_req, bus.mem_addr} !== {1'b1, exp_addr}) begin miscompares++; $display("FAIL alt_grant%0d got %h want %h", i, {bus.mem_req, bus.mem_addr}, {1'b1, exp_addr}); end
      if (i > 0) begin
        vectors++; if ({bus.dm_ready, bus.if_ready} !== ((i % 2 == 1) ? 2'b10 : 2'b01)) begin miscompares++; $display("FAIL alt_ready%0d got %b want %b", i, {bus.dm_ready, bus.if_ready}, (i % 2 == 1) ? 2'b10 : 2'b01); end
      end
      if (i % 2 == 1) begin
        vectors++; if (bus.dm_rdata !== 32'h5555_AAAA) begin miscompares++; $display("FAIL alt_load%0d got %h want 5555aaaa", i, bus.dm_rdata); end
      end
    end
    bus.if_req = 1'b0; bus.dm_req = 1'b0;
    cyc();
    vectors++; if ({bus.if_ready, bus.mem_req, bus.busy} !== 3'b100) begin miscompares++; $display("FAIL alt_end got %b want 100", {bus.if_ready, bus.mem_req, bus.busy}); end
    bus.mem_ack = 1'b0;
    cyc();
  endtask

  task automatic test_abort();
    bus.if_req = 1'b1; bus.if_addr = 32'h90; bus.if_abort = 1'b1;
    cyc();
    vectors++; if ({bus.mem_req, bus.busy, bus.stall_if} !== 3'b001) begin miscompares++; $display("FAIL abort_idle got %b want 001", {bus.mem_req, bus.busy, bus.stall_if}); end
    bus.if_abort = 1'b0; bus.if_addr = 32'h60;
    cyc();
    vectors++; if ({bus.busy, bus.mem_addr} !== {1'b1, 32'h60}) begin miscompares++; $display("FAIL abort_grant got %h want 100000060", {bus.busy, bus.mem_addr}); end
    bus.if_abort = 1'b1; bus.if_addr = 32'h80;
    cyc();
    bus.if_abort = 1'b0;
    vectors++; if (bus.mem_addr !== 32'h60) begin miscompares++; $display("FAIL abort_hold got %h want 60", bus.mem_addr); end
    cyc();
    bus.mem_ack = 1'b1; bus.mem_rdata = 32'h1234_5678;
    cyc();
    vectors++; if ({bus.if_ready, bus.busy, bus.mem_req, bus.stall_if} !== 4'b0001) begin miscompares++; $display("FAIL abort_noready got %b want 0001", {bus.if_ready, bus.busy, bus.mem_req, bus.stall_if}); end
    bus.mem_ack = 1'b0;
    cyc();
    vectors++; if ({bus.mem_req, bus.mem_addr} !== {1'b1, 32'h80}) begin miscompares++; $display("FAIL abort_refetch got %h want 100000080", {bus.mem_req, bus.mem_addr}); end
    bus.mem_ack = 1'b1; bus.mem_rdata = 32'h0BAD_C0DE;
    cyc();
    vectors++; if ({bus.if_ready, bus.if_rdata} !== {1'b1, 32'h0BAD_C0DE}) begin miscompares++; $display("FAIL abort_refetch_done got %h want 10badc0de", {bus.if_ready, bus.if_rdata}); end
    bus.mem_ack = 1'b0; bus.if_req = 1'b0;
    cyc();
  endtask

  task automatic test_reset_mid();
    bus.dm_req = 1'b1; bus.dm_we = 1'b0; bus.dm_be = 4'hF; bus.dm_addr = 32'h500;
    cyc();
    vectors++; if ({bus.busy, bus.mem_addr} !== {1'b1, 32'h500}) begin miscompares++; $display("FAIL rmid_grant got %h want 100000500", {bus.busy, bus.mem_addr}); end
    bus.mem_ack = 1'b1; bus.mem_rdata = 32'h9999_9999;
    #2 rst_n = 1'b0;
    #1;
    vectors++; if ({bus.mem_req, bus.busy} !== 2'b00) begin miscompares++; $display("FAIL rmid_async got %b want 00", {bus.mem_req, bus.busy}); end
    cyc();
    vectors++; if ({bus.dm_ready, bus.dm_rdata} !== 33'h0) begin miscompares++; $display("FAIL rmid_noready got %h want 0", {bus.dm_ready, bus.dm_rdata}); end
    bus.mem_ack = 1'b0; rst_n = 1'b1;
    cyc();
    vectors++; if ({bus.mem_req, bus.mem_we, bus.mem_addr} !== {2'b10, 32'h500}) begin miscompares++; $display("FAIL rmid_regrant got %h want 200000500", {bus.mem_req, bus.mem_we, bus.mem_addr}); end
    bus.mem_ack = 1'b1; bus.mem_rdata = 32'h7777_7777;
    cyc();
    vectors++; if ({bus.dm_ready, bus.dm_rdata} !== {1'b1, 32'h7777_7777}) begin miscompares++; $display("FAIL rmid_done got %h want 177777777", {bus.dm_ready, bus.dm_rdata}); end
    bus.mem_ack = 1'b0; bus.dm_req = 1'b0;
  endtask

  task automatic test_load_after_store();
    bus.dm_req = 1'b1; bus.dm_we = 1'b1; bus.dm_be = 4'hF; bus.dm_addr = 32'h100; bus.dm_wdata = 32'h0000_BEEF;
    cyc();
    vectors++; if ({bus.mem_we, bus.mem_wdata} !== {1'b1, 32'h0000_BEEF}) begin miscompares++; $display("FAIL las_store got %h want 10000beef", {bus.mem_we, bus.mem_wdata}); end
    bus.mem_ack = 1'b1; bus.mem_rdata = 32'hFFFF_FFFF;
    cyc();
    vectors++; if ({bus.dm_ready, bus.dm_rdata} !== {1'b1, 32'h7777_7777}) begin miscompares++; $display("FAIL las_store_rdata got %h want 177777777", {bus.dm_ready, bus.dm_rdata}); end
    bus.dm_we = 1'b0; bus.mem_ack = 1'b0;
    cyc();
    vectors++; if ({bus.mem_req, bus.mem_we, bus.mem_be, bus.mem_addr} !== {6'b10_1111, 32'h100}) begin miscompares++; $display("FAIL las_load_bus got %h want %h", {bus.mem_req, bus.mem_we, bus.mem_be, bus.mem_addr}, {6'b10_1111, 32'h100}); end
    bus.mem_ack = 1'b1; bus.mem_rdata = 32'h0000_BEEF;
    cyc();
    vectors++; if ({bus.dm_ready, bus.dm_rdata} !== {1'b1, 32'h0000_BEEF}) begin miscompares++; $display("FAIL las_load_rdata got %h want 10000beef", {bus.dm_ready, bus.dm_rdata}); end
    bus.mem_ack = 1'b0; bus.dm_req = 1'b0;
    cyc();
  endtask

  initial begin
    rst_n = 1'b0;
    bus.if_req = 1'b0; bus.if_addr = '0; bus.if_abort = 1'b0;
    bus.dm_req = 1'b0; bus.dm_we = 1'b0; bus.dm_be = '0; bus.dm_addr = '0; bus.dm_wdata = '0;
    bus.mem_ack = 1'b0; bus.mem_rdata = '0;
    test_reset();
    test_single_fetch();
    test_contention();
    test_alternation();
    test_abort();
    test_reset_mid();
    test_load_after_store();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
